gobou_core_lanes: RTL
=====================

Name: gobou_core_lanes

Overview:
Parametrised successor to the single-lane gobou datapath core. It computes LANES parallel dot products of one shared pixel stream against per-lane weight streams. Each lane applies round-to-nearest requantisation, an optional bias, saturation and an optional ReLU. A built-in sequencer with valid/ready handshakes on input and output replaces the externally driven oe/we strobes, and sits between the gobou controller and the output buffer.

Parameters:
DWIDTH, 16, signed width of pixel, weight, bias and result
LANES, 4, number of parallel output channels
LENWIDTH, 10, width of dot-product length field; max length 2^LENWIDTH-1
AWIDTH, 2*DWIDTH+LENWIDTH, accumulator width (overflow-free by construction)
QWIDTH, $clog2(AWIDTH), width of shift amount

Ports:
clk  in  1  clock
xrst  in  1  reset; synchronous, active-high (xrst=1 resets on the clk rising edge)
start  in  1  job request; honoured only in IDLE
len  in  LENWIDTH  dot-product length; sampled on start
qbits  in  QWIDTH  right-shift amount, must be < AWIDTH; sampled on start
bias_en  in  1  add bias; sampled on start
relu_en  in  1  apply ReLU; sampled on start
bias  in  LANES*DWIDTH  per-lane signed bias, lane i at [i*DWIDTH +: DWIDTH]; sampled on start
in_valid  in  1  pixel/weight beat valid
in_ready  out  1  core accepts a beat
pixel  in  DWIDTH  signed shared pixel
weight  in  LANES*DWIDTH  signed per-lane weights
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  LANES*DWIDTH  signed per-lane outputs
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE. in_ready=0, out_valid=0, busy=0, result=0. All lane accumulators, beat counter and latched config are cleared. Reset mid-job aborts the job with no partial output.
- IDLE:
  - start=1 and len>=1: latch len, qbits, bias_en, relu_en and bias; clear accumulators and counter; go to ACCUM.
  - start=1 and len==0: latch the same fields; accumulators stay 0; go to POST.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready: acc[i] += sext(pixel*weight[i]) (full 2*DWIDTH signed product) and count++.
  - No state change while in_valid=0.
  - The beat that makes count==len goes to POST. in_ready drops the following cycle.
- POST (exactly 1 cycle), per lane:
  - s = (acc + (qbits>0 ? 1<<(qbits-1) : 0)) >>> qbits, arithmetic shift, round-half-up.
  - If bias_en, s += sext(bias[i]).
  - Saturate s to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - If relu_en and s<0, s=0.
  - Register the value into result[i]. Go to OUT.
- OUT:
  - out_valid=1; result held stable.
  - out_ready=1 clears out_valid and returns to IDLE next cycle.
  - result keeps its last value after the handshake.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+2. start at t with len==0 gives out_valid=1 at t+2.
- start is ignored whenever busy=1, including the OUT cycle in which out_ready=1. A new job can be accepted one cycle after the output handshake at the earliest.
- Intermediate sums use AWIDTH+1 bits, so the bias add cannot wrap before saturation.
- The config and bias ports may change freely after start; only latched copies are used.
- in_valid outside ACCUM is ignored. out_ready outside OUT is ignored.

Test Plan:
1. Reset: hold xrst=1 for 2 cycles from a random state -> out_valid=0, in_ready=0, busy=0, result=0. Then drive in_valid=1 in IDLE -> nothing accumulated.
2. Basic dot product: DWIDTH=16, LANES=4, len=3, pixels 2,3,4, lane0 weights 1,1,1, lane1 weights -1,-1,-1, qbits=0, bias_en=0, relu_en=0 -> result lane0=9, lane1=-9. out_valid appears exactly 2 cycles after the third beat.
3. Rounding: len=1, pixel=384, weight lane0=1, lane1=-1, qbits=8 -> lane0=2, lane1=-1. Repeat with qbits=0 -> lane0=384, lane1=-384.
4. Saturation, ReLU and bias:
   - len=4, pixel=32767, weight lane0=32767, lane1=-32768, qbits=0 -> lane0=32767, lane1=-32768.
   - Same with relu_en=1 -> lane1=0.
   - len=0, bias_en=1, bias lane0=5, lane1=-7, relu_en=1 -> lane0=5, lane1=0.
5. Handshakes: len=4 with in_valid gaps of 0,2,1 idle cycles -> same result as gap-free. Hold out_ready=0 for 5 cycles -> out_valid and result stable throughout. start pulsed during ACCUM and OUT -> ignored. start one cycle after the handshake -> accepted.
6. Reset mid-ACCUM: assert xrst after 2 of 5 beats -> state IDLE, no out_valid. A following job with len=1, pixel=1, weight=1 -> result=1, so no stale accumulation.

Source files
------------

// File: rtl/gobou_core_lanes_if.sv
// Streaming bus of the gobou lane core: pixel/weight beats in, per-lane results out.
// The master side is the producer/consumer around the core; the slave side is the core.
interface gobou_core_lanes_if #(
  parameter int DWIDTH = 16,
  parameter int LANES  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DWIDTH-1:0]  pixel;
  logic [LANES*DWIDTH-1:0]   weight;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DWIDTH-1:0]   result;

  modport master (
    output in_valid, pixel, weight, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, pixel, weight, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/gobou_core_lanes.sv
// LANES parallel dot products of a shared pixel stream against per-lane weights,
// followed by round/bias/saturate/ReLU requantisation and a valid/ready output stage.
module gobou_core_lanes #(
  parameter int DWIDTH   = 16,
  parameter int LANES    = 4,
  parameter int LENWIDTH = 10,
  parameter int AWIDTH   = 2*DWIDTH + LENWIDTH,
  parameter int QWIDTH   = $clog2(AWIDTH)
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     start_i,
  input  logic [LENWIDTH-1:0]      len_i,
  input  logic [QWIDTH-1:0]        qbits_i,
  input  logic                     bias_en_i,
  input  logic                     relu_en_i,
  input  logic [LANES*DWIDTH-1:0]  bias_i,
  gobou_core_lanes_if.slave        dp,
  output logic                     busy_o
);

  // One guard bit above the accumulator keeps rounding and bias adds from wrapping.
  localparam int SW = AWIDTH + 1;
  localparam logic signed [SW-1:0] ONE  = SW'(1);
  localparam logic signed [SW-1:0] MAXV = (ONE <<< (DWIDTH-1)) - ONE;
  localparam logic signed [SW-1:0] MINV = -(ONE <<< (DWIDTH-1));

  typedef enum logic [1:0] {IDLE, ACCUM, POST, OUT} state_e;

  state_e                    state_q, state_d;
  logic [LENWIDTH-1:0]       len_q, cnt_q, cnt_d;
  logic [QWIDTH-1:0]         qbits_q;
  logic                      bias_en_q, relu_en_q;
  logic [LANES*DWIDTH-1:0]   bias_q;
  logic [LANES*DWIDTH-1:0]   result_q;
  logic signed [AWIDTH-1:0]  acc_q   [LANES];
  logic signed [AWIDTH-1:0]  acc_sum [LANES];
  logic signed [DWIDTH-1:0]  post_val[LANES];
  logic                      beat, last_beat;

  assign dp.in_ready  = (state_q == ACCUM);
  assign dp.out_valid = (state_q == OUT);
  assign dp.result    = result_q;
  assign busy_o       = (state_q != IDLE);

  assign beat      = dp.in_valid && (state_q == ACCUM);
  assign cnt_d     = cnt_q + LENWIDTH'(1);
  assign last_beat = (cnt_d == len_q);

  always_comb begin
    // NOTE: default first so every path assigns state_d; a missing branch would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? POST : ACCUM;
      ACCUM:   if (beat && last_beat) state_d = POST;
      POST:    state_d = OUT;
      OUT:     if (dp.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (xrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DWIDTH-1:0]   w, b, sat;
    logic signed [2*DWIDTH-1:0] prod;
    logic signed [SW-1:0]       acc_x, rnd, shifted, bias_x, biased;

    assign w          = dp.weight[i*DWIDTH +: DWIDTH];
    assign prod       = dp.pixel * w;
    assign acc_sum[i] = acc_q[i] + AWIDTH'(prod);

    // Round half up: add half an output LSB before the arithmetic shift.
    assign acc_x   = SW'(acc_q[i]);
    assign rnd     = (qbits_q == '0) ? '0 : (ONE <<< (qbits_q - QWIDTH'(1)));
    assign shifted = (acc_x + rnd) >>> qbits_q;
    assign b       = bias_q[i*DWIDTH +: DWIDTH];
    assign bias_x  = bias_en_q ? SW'(b) : '0;
    assign biased  = shifted + bias_x;

    assign sat = (biased > MAXV) ? MAXV[DWIDTH-1:0] :
                 (biased < MINV) ? MINV[DWIDTH-1:0] : biased[DWIDTH-1:0];
    assign post_val[i] = (relu_en_q && sat[DWIDTH-1]) ? '0 : sat;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      qbits_q   <= '0;
      bias_en_q <= 1'b0;
      relu_en_q <= 1'b0;
      bias_q    <= '0;
      result_q  <= '0;
      // NOTE: the accumulators are a handful of flops, not a RAM, so they are
      // cleared in reset to guarantee an aborted job leaves nothing behind.
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        len_q     <= len_i;
        qbits_q   <= qbits_i;
        bias_en_q <= bias_en_i;
        relu_en_q <= relu_en_i;
        bias_q    <= bias_i;
        cnt_q     <= '0;
        for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      end
      if (beat) begin
        cnt_q <= cnt_d;
        for (int i = 0; i < LANES; i++) acc_q[i] <= acc_sum[i];
      end
      if (state_q == POST) begin
        for (int i = 0; i < LANES; i++) result_q[i*DWIDTH +: DWIDTH] <= post_val[i];
      end
    end
  end

endmodule
